// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle for fifo_sync_param: write/read requests, data and status flags.
interface fifo_sync_param_if #(
    parameter int W  = 4,
    parameter int CW = 8
);
    logic          flush;
    logic          wr;
    logic [W-1:0]  in;
    logic          rd;
    logic [W-1:0]  out;
    logic          o_full;
    logic          o_empty;
    logic          o_almost_full;
    logic          o_almost_empty;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_underflow;

    modport master (
        output flush, wr, in, rd,
        input  out, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  flush, wr, in, rd,
        output out, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock register FIFO with occupancy, threshold flags, flush and sticky errors.
// Define FIFO_SYNC_PARAM_OUTREG_EN for a registered (1-cycle latency) read port instead of show-ahead.
module fifo_sync_param #(
    parameter int bw         = 4,
    parameter int simd       = 1,
    parameter int depth_log2 = 7,
    parameter int af_thresh  = 120,
    parameter int ae_thresh  = 8
) (
    input  logic          rd_clk,
    input  logic          reset,
    fifo_sync_param_if.slave bus
);
    localparam int W     = simd * bw;
    localparam int AW    = depth_log2;
    localparam int CW    = depth_log2 + 1;
    localparam int D     = 1 << depth_log2;
    localparam int LB    = (AW < 4) ? AW : 4;
    localparam int NLEAF = 1 << (AW - LB);

    logic [W-1:0]  mem [D];
    logic [CW-1:0] wr_ptr, rd_ptr, count;
    logic          overflow, underflow;
    logic          full, empty, wr_acc, rd_acc;
    logic [AW-1:0] ra;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign wr_acc = bus.wr & ~full;
    assign rd_acc = bus.rd & ~empty;
    assign ra     = rd_ptr[AW-1:0];

    always_ff @(posedge rd_clk) begin
        if (reset || bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.wr && full)  overflow  <= 1'b1;
            if (bus.rd && empty) underflow <= 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!reset && !bus.flush && wr_acc) mem[wr_ptr[AW-1:0]] <= bus.in;
    end

    // Read mux: 16:1 leaves on the low address bits, then one stage on the high bits.
    logic [W-1:0] leaf [NLEAF];
    logic [W-1:0] head;

    genvar g;
    for (g = 0; g < NLEAF; g++) begin : g_leaf
        localparam logic [AW-1:0] BASE = AW'(g * 16);
        assign leaf[g] = mem[BASE | AW'(ra[LB-1:0])];
    end

    if (NLEAF == 1) begin : g_one
        assign head = leaf[0];
    end else begin : g_tree
        assign head = leaf[ra[AW-1:LB]];
    end

`ifdef FIFO_SYNC_PARAM_OUTREG_EN
    logic [W-1:0] out_q;
    always_ff @(posedge rd_clk) begin
        if (reset)                      out_q <= '0;
        else if (!bus.flush && rd_acc)  out_q <= head;
    end
    assign bus.out = out_q;
`else
    assign bus.out = head;
`endif

    assign bus.o_full         = full;
    assign bus.o_empty        = empty;
    assign bus.o_almost_full  = (count >= CW'(af_thresh));
    assign bus.o_almost_empty = (count <= CW'(ae_thresh));
    assign bus.o_count        = count;
    assign bus.o_overflow     = overflow;
    assign bus.o_underflow    = underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param at default parameters (W=4, D=128).
module tb_fifo_sync_param;
    localparam int W  = 4;
    localparam int CW = 8;

    logic rd_clk = 1'b0;
    logic reset  = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_sync_param_if #(.W(W), .CW(CW)) bus ();

    fifo_sync_param #(
        .bw(4), .simd(1), .depth_log2(7), .af_thresh(120), .ae_thresh(8)
    ) dut (
        .rd_clk (rd_clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    task automatic step();
        @(posedge rd_clk);
        @(negedge rd_clk);
    endtask

    task automatic do_reset();
        bus.flush = 0; bus.wr = 0; bus.rd = 0; bus.in = '0;
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic push(input logic [W-1:0] v);
        bus.wr = 1; bus.in = v;
        step();
        bus.wr = 0;
    endtask

    // Returns the datum delivered by one accepted read in either read-port mode.
    task automatic pop(output logic [W-1:0] d);
        bus.rd = 1;
`ifdef FIFO_SYNC_PARAM_OUTREG_EN
        step();
        d = bus.out;
`else
        d = bus.out;
        step();
`endif
        bus.rd = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", bus.o_empty); end
        tests++; if (bus.o_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", bus.o_full); end
        tests++; if (bus.o_almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae got %b want 1", bus.o_almost_empty); end
        tests++; if (bus.o_almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got %b want 0", bus.o_almost_full); end
        tests++; if (bus.o_count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
        tests++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            fails++; $display("FAIL reset_err got ovf=%b unf=%b want 0/0", bus.o_overflow, bus.o_underflow); end
`ifdef FIFO_SYNC_PARAM_OUTREG_EN
        tests++; if (bus.out !== 4'h0) begin fails++; $display("FAIL reset_out got %h want 0", bus.out); end
`endif
    endtask

    task automatic test_basic();
        logic [W-1:0] d;
        do_reset();
        for (int i = 1; i <= 5; i++) push(W'(i));
        tests++; if (bus.o_count !== 8'd5) begin fails++; $display("FAIL basic_count got %0d want 5", bus.o_count); end
        tests++; if (bus.o_empty !== 1'b0) begin fails++; $display("FAIL basic_nonempty got %b want 0", bus.o_empty); end
        for (int i = 1; i <= 5; i++) begin
            pop(d);
            tests++; if (d !== W'(i)) begin fails++; $display("FAIL basic_data[%0d] got %h want %h", i, d, W'(i)); end
        end
        tests++; if (bus.o_empty !== 1'b1 || bus.o_count !== 8'd0) begin
            fails++; $display("FAIL basic_drained got empty=%b count=%0d want 1/0", bus.o_empty, bus.o_count); end
    endtask

    task automatic test_fill_overflow();
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < 128; i++) push(W'(i % 16));
        tests++; if (bus.o_full !== 1'b1 || bus.o_count !== 8'd128) begin
            fails++; $display("FAIL fill_full got full=%b count=%0d want 1/128", bus.o_full, bus.o_count); end
        tests++; if (bus.o_almost_full !== 1'b1) begin fails++; $display("FAIL fill_af got %b want 1", bus.o_almost_full); end
        push(4'hE);
        tests++; if (bus.o_overflow !== 1'b1 || bus.o_count !== 8'd128) begin
            fails++; $display("FAIL fill_ovf got ovf=%b count=%0d want 1/128", bus.o_overflow, bus.o_count); end
        for (int i = 0; i < 128; i++) begin
            pop(d);
            tests++; if (d !== W'(i % 16)) begin fails++; $display("FAIL fill_drain[%0d] got %h want %h", i, d, W'(i % 16)); end
        end
        tests++; if (bus.o_empty !== 1'b1 || bus.o_overflow !== 1'b1) begin
            fails++; $display("FAIL fill_sticky got empty=%b ovf=%b want 1/1", bus.o_empty, bus.o_overflow); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        do_reset();
        for (int n = 0; n < 64; n++) push(W'(n % 16));
        // Stream 300 simultaneous read/write cycles; read k must return the k-th value written.
        for (int k = 0; k < 300; k++) begin
            bus.wr = 1; bus.rd = 1; bus.in = W'((64 + k) % 16);
`ifdef FIFO_SYNC_PARAM_OUTREG_EN
            step();
            d = bus.out;
`else
            d = bus.out;
            step();
`endif
            tests++; if (d !== W'(k % 16)) begin fails++; $display("FAIL b2b_data[%0d] got %h want %h", k, d, W'(k % 16)); end
        end
        bus.wr = 0; bus.rd = 0;
        tests++; if (bus.o_count !== 8'd64) begin fails++; $display("FAIL b2b_count got %0d want 64", bus.o_count); end
        tests++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            fails++; $display("FAIL b2b_err got ovf=%b unf=%b want 0/0", bus.o_overflow, bus.o_underflow); end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < 128; i++) push(W'(i % 16));
        bus.wr = 1; bus.rd = 1; bus.in = 4'h7;
        step();
        bus.wr = 0; bus.rd = 0;
        tests++; if (bus.o_count !== 8'd127 || bus.o_full !== 1'b0) begin
            fails++; $display("FAIL simul_full got count=%0d full=%b want 127/0", bus.o_count, bus.o_full); end
        tests++; if (bus.o_overflow !== 1'b1) begin fails++; $display("FAIL simul_full_ovf got %b want 1", bus.o_overflow); end
        do_reset();
        bus.wr = 1; bus.rd = 1; bus.in = 4'hA;
        step();
        bus.wr = 0; bus.rd = 0;
        tests++; if (bus.o_count !== 8'd1 || bus.o_underflow !== 1'b1) begin
            fails++; $display("FAIL simul_empty got count=%0d unf=%b want 1/1", bus.o_count, bus.o_underflow); end
        pop(d);
        tests++; if (d !== 4'hA) begin fails++; $display("FAIL simul_empty_data got %h want a", d); end
    endtask

    task automatic test_flush();
        logic [W-1:0] d;
        do_reset();
        bus.rd = 1; step(); bus.rd = 0;
        for (int i = 0; i < 10; i++) push(W'(i + 1));
        tests++; if (bus.o_underflow !== 1'b1 || bus.o_count !== 8'd10) begin
            fails++; $display("FAIL flush_pre got unf=%b count=%0d want 1/10", bus.o_underflow, bus.o_count); end
        bus.flush = 1; bus.wr = 1; bus.in = 4'hF;
        step();
        bus.flush = 0; bus.wr = 0;
        tests++; if (bus.o_count !== 8'd0 || bus.o_empty !== 1'b1) begin
            fails++; $display("FAIL flush_state got count=%0d empty=%b want 0/1", bus.o_count, bus.o_empty); end
        tests++; if (bus.o_underflow !== 1'b0 || bus.o_overflow !== 1'b0) begin
            fails++; $display("FAIL flush_err got ovf=%b unf=%b want 0/0", bus.o_overflow, bus.o_underflow); end
        push(4'h3);
        pop(d);
        tests++; if (d !== 4'h3 || bus.o_empty !== 1'b1) begin
            fails++; $display("FAIL flush_after got data=%h empty=%b want 3/1", d, bus.o_empty); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.rd = 1; step(); bus.rd = 0;
        for (int i = 0; i < 5; i++) push(W'(i + 9));
        bus.wr = 1; bus.rd = 1; bus.in = 4'h5; reset = 1;
        step();
        bus.wr = 0; bus.rd = 0; reset = 0;
        tests++; if (bus.o_count !== 8'd0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0) begin
            fails++; $display("FAIL midrst_state got count=%0d empty=%b full=%b want 0/1/0", bus.o_count, bus.o_empty, bus.o_full); end
        tests++; if (bus.o_almost_empty !== 1'b1 || bus.o_almost_full !== 1'b0) begin
            fails++; $display("FAIL midrst_thr got ae=%b af=%b want 1/0", bus.o_almost_empty, bus.o_almost_full); end
        tests++; if (bus.o_underflow !== 1'b0 || bus.o_overflow !== 1'b0) begin
            fails++; $display("FAIL midrst_err got ovf=%b unf=%b want 0/0", bus.o_overflow, bus.o_underflow); end
`ifdef FIFO_SYNC_PARAM_OUTREG_EN
        tests++; if (bus.out !== 4'h0) begin fails++; $display("FAIL midrst_out got %h want 0", bus.out); end
`endif
    endtask

    task automatic test_thresholds();
        logic [W-1:0] d;
        do_reset();
        for (int c = 0; c <= 128; c++) begin
            tests++; if (bus.o_count !== CW'(c) || bus.o_almost_empty !== (c <= 8) || bus.o_almost_full !== (c >= 120)) begin
                fails++; $display("FAIL thr_up[%0d] got count=%0d ae=%b af=%b want %0d/%b/%b",
                                  c, bus.o_count, bus.o_almost_empty, bus.o_almost_full, c, c <= 8, c >= 120); end
            if (c < 128) push(W'(c % 16));
        end
        for (int c = 127; c >= 0; c--) begin
            pop(d);
            tests++; if (bus.o_count !== CW'(c) || bus.o_almost_empty !== (c <= 8) || bus.o_almost_full !== (c >= 120)) begin
                fails++; $display("FAIL thr_dn[%0d] got count=%0d ae=%b af=%b want %0d/%b/%b",
                                  c, bus.o_count, bus.o_almost_empty, bus.o_almost_full, c, c <= 8, c >= 120); end
        end
    endtask

    initial begin
        bus.flush = 0; bus.wr = 0; bus.rd = 0; bus.in = '0;
        @(negedge rd_clk);
        test_reset();
        test_basic();
        test_fill_overflow();
        test_back_to_back();
        test_simultaneous();
        test_flush();
        test_reset_midstream();
        test_thresholds();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; successor to the fixed-depth register FIFOs used in the accumulation and output paths.
- Generalised in width (bw × simd) and depth (2^depth_log2).
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
- Both read and write sides run on rd_clk. Storage is a register array; no SRAM macro.

Parameters:
- bw, 4, bits per SIMD lane
- simd, 1, number of lanes; data width W = simd*bw
- depth_log2, 7, address width; depth D = 2^depth_log2 (min 1)
- af_thresh, 120, almost-full asserted when count >= af_thresh (1..D)
- ae_thresh, 8, almost-empty asserted when count <= ae_thresh (0..D-1)

Ports:
- rd_clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of pointers, count and error flags
- wr  in  1  write request
- in  in  W  write data
- rd  in  1  read request
- out  out  W  read data
- o_full  out  1  count == D
- o_empty  out  1  count == 0
- o_almost_full  out  1  count >= af_thresh
- o_almost_empty  out  1  count <= ae_thresh
- o_count  out  depth_log2+1  current occupancy 0..D
- o_overflow  out  1  sticky: write attempted while full
- o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset is synchronous, active-high, on rd_clk.
  - Reset clears wr_ptr, rd_ptr (each depth_log2+1 bits, MSB is the wrap bit), count, o_overflow and o_underflow.
  - After reset: o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0 (given af_thresh>=1).
  - Storage array is not reset.
- Accept rules use flags from the current cycle's registered state:
  - wr_acc = wr & ~o_full
  - rd_acc = rd & ~o_empty
- On wr_acc, mem[wr_ptr[depth_log2-1:0]] <= in and wr_ptr increments.
- On rd_acc, rd_ptr increments.
- Pointers wrap naturally modulo 2D:
  - empty when the pointers are equal
  - full when the address bits are equal and the wrap bits differ
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither occur
  - o_count always equals wr_ptr - rd_ptr (mod 2D)
- Simultaneous rd and wr:
  - When full, only the read is accepted. The write is rejected and o_overflow is set, so the FIFO is not-full next cycle.
  - When empty, only the write is accepted and o_underflow is set. The read is not served that cycle.
- Error flags:
  - o_overflow sets on wr & o_full; o_underflow sets on rd & o_empty.
  - Both are sticky until reset or flush.
- All status outputs derive from registered pointers/count and change one edge after the causing request.
- flush has priority over rd and wr in the same cycle:
  - pointers, count and error flags are cleared
  - the write that cycle is discarded
  - storage is untouched
- Reset asserted mid-stream aborts any in-flight access; state after release is identical to power-on reset.
- Default read path (show-ahead): out = mem[rd_ptr[depth_log2-1:0]] combinationally, zero-latency.
  - out is valid whenever o_empty=0 and is don't-care when empty.
- Read mux is built as a balanced tree (16:1 leaf muxes, then a final stage) for any depth.

Optional Feature:
- Macro FIFO_SYNC_PARAM_OUTREG_EN.
- Defined:
  - out is a W-bit register, reset to 0.
  - On rd_acc it loads mem[rd_ptr]; otherwise it holds.
  - Read latency is 1 cycle: data for a read accepted at edge N is visible after edge N.
  - flush does not clear it.
- Undefined: show-ahead combinational out as above. Flags and count are identical in both modes.

Test Plan:
- Reset, then write 0x1..0x5 (bw=4) on 5 consecutive cycles -> o_count=5, o_empty=0; reading 5 cycles returns 1,2,3,4,5 in order, then o_empty=1, o_count=0.
- Fill D=128 entries with values i mod 16 -> o_full=1, o_count=128, o_almost_full asserted since count 120. An extra write -> o_overflow=1, contents unchanged; draining returns the original 128 values.
- With 64 entries, assert rd and wr together for 300 cycles (pointers wrap twice) -> o_count stays 64, output sequence matches the write order exactly.
- When full, assert rd+wr in the same cycle -> only the read is accepted, o_count=127, o_overflow=1. When empty, rd+wr -> o_count=1, o_underflow=1, the written datum is read next.
- With 10 entries, assert flush together with wr -> next cycle o_count=0, o_empty=1, error flags cleared, the flushed write is absent. Assert reset mid-stream -> same state as power-on.
- Threshold walk from 0 to 128 and back -> o_almost_empty high for count<=8, o_almost_full high for count>=120, each toggling exactly one edge after the crossing. With FIFO_SYNC_PARAM_OUTREG_EN, read data lags rd by 1 cycle and out=0 after reset.
